ifetch_stage: RTL

//  Instruction fetch stage directly downstream of the program counter. Takes the current PC,

---
 rtl/rv_fetch_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/ifetch_stage.sv | 93 +++++++++
 3 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package rv_fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  // One in-order fetch slot: PC is known at grant, instr arrives later.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order fetch buffer: entries are allocated on grant, filled in order by
// responses and popped from the head once filled.
module fetch_fifo
  import rv_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = AW + 1
) (
  input  logic            clk,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic            alloc_i,
  input  logic [XLEN-1:0] alloc_pc_i,
  input  logic            fill_i,
  input  logic [XLEN-1:0] fill_data_i,
  input  logic            pop_i,
  output fetch_entry_t    head_o,
  output logic [CW-1:0]   used_o,
  output logic [CW-1:0]   pend_o
);

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   tail_q, fill_q, head_q;
  logic [CW-1:0]   used_q, used_d, pend_q, pend_d;

  // Occupancy (allocated) and pending (allocated but not yet filled) counts.
  always_comb begin
    used_d = used_q + CW'(alloc_i) - CW'(pop_i);
    pend_d = pend_q + CW'(alloc_i) - CW'(fill_i);
  end

  // Pointer, count and entry storage; clear takes priority over every other update.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      tail_q <= '0;
      fill_q <= '0;
      head_q <= '0;
      used_q <= '0;
      pend_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clear_i) begin
      tail_q <= '0;
      fill_q <= '0;
      head_q <= '0;
      used_q <= '0;
      pend_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i].filled <= 1'b0;
    end else begin
      used_q <= used_d;
      pend_q <= pend_d;
      if (alloc_i) begin
        mem_q[tail_q] <= '{pc: alloc_pc_i, instr: '0, filled: 1'b0};
        tail_q        <= tail_q + AW'(1);
      end
      if (fill_i) begin
        mem_q[fill_q].instr  <= fill_data_i;
        mem_q[fill_q].filled <= 1'b1;
        fill_q               <= fill_q + AW'(1);
      end
      // Dropping filled on pop keeps an empty head from looking valid.
      if (pop_i) begin
        mem_q[head_q].filled <= 1'b0;
        head_q               <= head_q + AW'(1);
      end
    end
  end

  assign head_o = mem_q[head_q];
  assign used_o = used_q;
  assign pend_o = pend_q;

endmodule

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: issues word requests for the current PC, pairs
// in-order responses with their PC and hands {pc, instr} to decode.
module ifetch_stage
  import rv_fetch_pkg::*;
#(
  parameter int WIDTH = XLEN,  // entry type is XLEN wide; keep these equal
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] pc_i,
  output logic             pc_stall_o,
  input  logic             flush_i,
  output logic             imem_req_o,
  output logic [WIDTH-1:0] imem_addr_o,
  input  logic             imem_gnt_i,
  input  logic             imem_rvalid_i,
  input  logic [WIDTH-1:0] imem_rdata_i,
  output logic             id_valid_o,
  input  logic             id_ready_i,
  output logic [WIDTH-1:0] id_instr_o,
  output logic [WIDTH-1:0] id_pc_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_entry_t  head;
  logic [CW-1:0] used, pend;
  logic [CW-1:0] drop_q, drop_d;
  logic          alloc, fill, pop, rv_used;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_i       (rst_i),
    .clear_i     (flush_i),
    .alloc_i     (alloc),
    .alloc_pc_i  (pc_i),
    .fill_i      (fill),
    .fill_data_i (imem_rdata_i),
    .pop_i       (pop),
    .head_o      (head),
    .used_o      (used),
    .pend_o      (pend)
  );

  // Request / handshake decode. Occupancy is registered, so a pop only frees
  // a slot for the following cycle; reset forces the request low right away.
  always_comb begin
    imem_req_o = !rst_i && !flush_i && (drop_q == '0) && (used < CW'(DEPTH));
    alloc      = imem_req_o && imem_gnt_i;
    pc_stall_o = !alloc;
    fill       = imem_rvalid_i && !flush_i && (drop_q == '0) && (pend != '0);
    pop        = head.filled && id_ready_i && !flush_i;
    // A response is accounted for if it drains a drop or fills a real slot.
    rv_used    = imem_rvalid_i && ((drop_q != '0) || (pend != '0));
  end

  assign imem_addr_o = {pc_i[WIDTH-1:2], 2'b00};

  // Responses still owed for squashed requests; drop_q is added in so a
  // second flush before the drain finishes does not lose any.
  always_comb begin
    drop_d = drop_q;
    if (flush_i)
      drop_d = drop_q + pend - CW'(rv_used);
    else if (imem_rvalid_i && (drop_q != '0))
      drop_d = drop_q - CW'(1);
  end

  // Drop counter register.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) drop_q <= '0;
    else       drop_q <= drop_d;
  end

  // Decode-side outputs are forced to a harmless NOP at PC 0 when idle.
  always_comb begin
    id_valid_o = head.filled;
    id_instr_o = head.filled ? head.instr : NOP_INSTR;
    id_pc_o    = head.filled ? head.pc    : '0;
  end

`ifndef SYNTHESIS
  // A response nobody is waiting for means the memory broke ordering.
  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (rst_i)
    imem_rvalid_i |-> (drop_q != '0) || (pend != '0));

  // An ungranted request must hold with a stable address unless flushed.
  a_req_stable: assert property (@(posedge clk) disable iff (rst_i)
    imem_req_o && !imem_gnt_i |=> flush_i || (imem_req_o && $stable(imem_addr_o)));
`endif

endmodule
